apb_to_obi: RTL and testbench

APB_TO_OBI -- requirements
Module: apb_to_obi

---
 rtl/apb_to_obi.sv | 141 ++++++++++++++
 tb/tb_apb_to_obi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_obi.sv
//------------------------------------------------------------------------------
// Module      : apb_to_obi
// Description : APB slave to OBI manager bridge; one OBI transaction per APB
//               transfer. Optional macro APB_TO_OBI_PSTRB_EN forwards pstrb_i
//               as the write byte enables (otherwise writes use all-ones).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_to_obi #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i,
    output logic                   obi_rready_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   be_q, be_d;
    logic [DataWidth-1:0]   prdata_q, prdata_d;
    logic                   err_q, err_d;
    logic [StrbWidth-1:0]   wr_be;

`ifdef APB_TO_OBI_PSTRB_EN
    assign wr_be = pstrb_i;
`else
    logic unused_pstrb;
    assign wr_be        = '1;
    assign unused_pstrb = ^pstrb_i;
`endif

    // OBI is word addressed here; the byte offset bits are dropped at latch time.
    logic unused_paddr_lsb;
    assign unused_paddr_lsb = ^paddr_i[1:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        prdata_d = prdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = REQ;
                    addr_d  = {paddr_i[AddrWidth-1:2], 2'b00};
                    we_d    = pwrite_i;
                    wdata_d = pwrite_i ? pwdata_i : '0;
                    be_d    = pwrite_i ? wr_be : '1;
                end
            end
            REQ: begin
                if (obi_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (obi_rvalid_i) begin
                    state_d = DONE;
                    err_d   = obi_err_i;
                    if (!we_q) begin
                        prdata_d = obi_rdata_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

    // A dropped psel_i lets the OBI side finish but suppresses the APB response.
    assign pready_o     = (state_q == DONE) && psel_i;
    assign pslverr_o    = pready_o && err_q;
    assign prdata_o     = prdata_q;
    assign obi_req_o    = (state_q == REQ);
    assign obi_addr_o   = addr_q;
    assign obi_we_o     = we_q;
    assign obi_be_o     = be_q;
    assign obi_wdata_o  = wdata_q;
    assign obi_rready_o = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_apb_to_obi.sv
//------------------------------------------------------------------------------
// Module      : tb_apb_to_obi
// Description : Directed self-checking bench for apb_to_obi.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_to_obi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [31:0] paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [3:0]  pstrb_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        obi_req_o;
    logic        obi_gnt_i = 1'b0;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;
    logic        obi_err_i = 1'b0;
    logic        obi_rready_o;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int pr_cnt = 0;
    int hs_base;
    int pr_base;

    apb_to_obi #(.AddrWidth(32), .DataWidth(32)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .psel_i       (psel_i),
        .penable_i    (penable_i),
        .pwrite_i     (pwrite_i),
        .paddr_i      (paddr_i),
        .pwdata_i     (pwdata_i),
        .pstrb_i      (pstrb_i),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i),
        .obi_rready_o (obi_rready_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (obi_req_o && obi_gnt_i) hs_cnt <= hs_cnt + 1;
            if (pready_o)               pr_cnt <= pr_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_wr_be(input logic [3:0] s);
`ifdef APB_TO_OBI_PSTRB_EN
        return s;
`else
        return 4'hF;
`endif
    endfunction

    // Called just after a rising edge; ends at the falling edge of the DONE cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int gnt_dly, input logic [31:0] rd,
                        input logic err, input logic [31:0] exp_prdata, input logic [3:0] exp_be);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = wd; pstrb_i = strb;
        @(negedge clk_i);
        check("setup_pready", pready_o, 0);
        check("setup_req", obi_req_o, 0);
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int i = 0; i <= gnt_dly; i++) begin
            obi_gnt_i = (i == gnt_dly);
            @(negedge clk_i);
            check("req", obi_req_o, 1);
            check("req_addr", obi_addr_o, {addr[31:2], 2'b00});
            check("req_we", obi_we_o, wr);
            check("req_wdata", obi_wdata_o, wr ? wd : 32'h0);
            check("req_be", obi_be_o, exp_be);
            check("req_pready", pready_o, 0);
            @(posedge clk_i); #1;
        end
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = rd; obi_err_i = err;
        @(negedge clk_i);
        check("rsp_req", obi_req_o, 0);
        check("rsp_pready", pready_o, 0);
        @(posedge clk_i); #1;
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
        @(negedge clk_i);
        check("done_pready", pready_o, 1);
        check("done_pslverr", pslverr_o, err);
        check("done_prdata", prdata_o, exp_prdata);
    endtask

    task automatic go_idle();
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        check("idle_pready", pready_o, 0);
        check("idle_pslverr", pslverr_o, 0);
    endtask

    initial begin
        @(negedge clk_i);
        check("rst_req", obi_req_o, 0);
        check("rst_pready", pready_o, 0);
        check("rst_pslverr", pslverr_o, 0);
        check("rst_addr", obi_addr_o, 0);
        check("rst_wdata", obi_wdata_o, 0);
        check("rst_be", obi_be_o, 0);
        check("rst_we", obi_we_o, 0);
        check("rst_prdata", prdata_o, 0);
        check("rst_rready", obi_rready_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Read, immediate grant: pready three cycles after setup
        @(posedge clk_i); #1;
        xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF);
        go_idle();

        // Write with grant delayed three cycles; prdata keeps the last read
        @(posedge clk_i); #1;
        xfer(1'b1, 32'h0000_2000, 32'h12345678, 4'b0011, 3, 32'h0, 1'b0, 32'hDEADBEEF,
             exp_wr_be(4'b0011));
        go_idle();

        // Unaligned read that returns an error
        @(posedge clk_i); #1;
        xfer(1'b0, 32'h0000_0003, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 4'hF);
        go_idle();

        // Back-to-back writes
        hs_base = hs_cnt; pr_base = pr_cnt;
        @(posedge clk_i); #1;
        xfer(1'b1, 32'h0000_3000, 32'hA5A5A5A5, 4'b1100, 0, 32'h0, 1'b0, 32'h0BADF00D,
             exp_wr_be(4'b1100));
        @(posedge clk_i); #1;
        xfer(1'b1, 32'h0000_3004, 32'h11111111, 4'b0001, 1, 32'h0, 1'b0, 32'h0BADF00D,
             exp_wr_be(4'b0001));
        go_idle();
        check("b2b_handshakes", hs_cnt - hs_base, 2);
        check("b2b_pready_pulses", pr_cnt - pr_base, 2);

        // psel dropped mid-transfer: OBI finishes, no pready pulse
        pr_base = pr_cnt;
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0000_0040;
        @(posedge clk_i); #1;
        psel_i = 1'b0; obi_gnt_i = 1'b1;
        @(negedge clk_i);
        check("abort_req", obi_req_o, 1);
        @(posedge clk_i); #1;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h55;
        @(posedge clk_i); #1;
        obi_rvalid_i = 1'b0; obi_rdata_i = '0;
        @(negedge clk_i);
        check("abort_done_pready", pready_o, 0);
        go_idle();
        check("abort_pready_pulses", pr_cnt - pr_base, 0);

        // Reset while waiting for rvalid, then a stray rvalid
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h0000_0080;
        pwdata_i = 32'hFFFF0000; pstrb_i = 4'hF;
        @(posedge clk_i); #1;
        penable_i = 1'b1; obi_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        obi_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_req", obi_req_o, 0);
        check("mid_rst_addr", obi_addr_o, 0);
        check("mid_rst_wdata", obi_wdata_o, 0);
        check("mid_rst_we", obi_we_o, 0);
        check("mid_rst_be", obi_be_o, 0);
        check("mid_rst_prdata", prdata_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hCAFE0001; obi_err_i = 1'b1;
        @(posedge clk_i); #1;
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_pready", pready_o, 0);
        check("post_rst_pslverr", pslverr_o, 0);
        check("post_rst_req", obi_req_o, 0);
        check("post_rst_prdata", prdata_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("post_rst_pready2", pready_o, 0);
        check("post_rst_addr", obi_addr_o, 0);
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
